pipeline_foreground_fetch: RTL and testbench

Downstream neighbour of the foreground scale stage. Each cycle it takes a foreground coordinate and its active flag and issues a read to the foreground frame-buffer memory port. It returns the fetched pixel at a fixed latency, so the mixer sees the foreground aligned with the background pipeline. Memory responses arrive in order with variable latency; a response that misses its deadline is replaced by an invalid (transparent) pixel and counted.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/pipeline_foreground_fetch_if.sv | 23 ++
 rtl/fetch_slot_ring.sv | 110 +++++++++++
 rtl/pipeline_foreground_fetch.sv | 96 +++++++++
 tb/tb_pipeline_foreground_fetch.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the display fetch pipeline.
//   pixel_t          : one RGB 4:4:4 pixel
//   DEF_RESOLUTION_* : default frame geometry
//   addr_of(x, y)    : frame-buffer word address y*800 + x as a shift-add
//                      constant multiply, shared with the background fetch
package pipeline_pkg;

   localparam int DEF_RESOLUTION_X = 800;
   localparam int DEF_RESOLUTION_Y = 600;
   localparam int DEF_PRECISION    = 10;
   localparam int DEF_PIXEL_WIDTH  = 12;
   localparam int DEF_ADDR_WIDTH   = 19;

   typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

   // 800 = 512 + 256 + 32, so y*800 needs only three shifted copies of y.
   function automatic logic [DEF_ADDR_WIDTH-1:0] addr_of(
      input logic [DEF_PRECISION-1:0] x,
      input logic [DEF_PRECISION-1:0] y
   );
      logic [DEF_ADDR_WIDTH-1:0] xw;
      logic [DEF_ADDR_WIDTH-1:0] yw;
      xw = DEF_ADDR_WIDTH'(x);
      yw = DEF_ADDR_WIDTH'(y);
      return (yw << 9) + (yw << 8) + (yw << 5) + xw;
   endfunction

endpackage

// File: rtl/pipeline_foreground_fetch_if.sv
// Foreground frame-buffer read port.
//   mem_req/mem_addr  : read request from the fetch stage
//   mem_ready         : memory accepts the request this cycle
//   mem_rvalid/rdata  : in-order read response strobe and data
// Handshake: a request transfers only in a cycle where mem_req && mem_ready;
// mem_req is not held, so a request seen with mem_ready low is gone. Each
// mem_rvalid is a single-cycle strobe with no backpressure, one per accepted
// request, returned in request order.
interface pipeline_foreground_fetch_if #(
   parameter int ADDR_WIDTH  = 19,
   parameter int PIXEL_WIDTH = 12
);
   logic                   mem_req;
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic                   mem_ready;
   logic                   mem_rvalid;
   logic [PIXEL_WIDTH-1:0] mem_rdata;

   modport master (output mem_req, output mem_addr,
                   input  mem_ready, input mem_rvalid, input mem_rdata);
   modport slave  (input  mem_req, input mem_addr,
                   output mem_ready, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/fetch_slot_ring.sv
// Slot ring aligning variable-latency memory responses to a fixed latency.
//   advance      : pipeline moves this cycle (allocate one slot, retire one)
//   alloc_issued : the slot being allocated has an accepted request
//   rsp_valid    : in-order memory response strobe, rsp_data its pixel
//   out_pixel    : retired pixel, 0 when not filled in time
//   out_valid    : out_pixel holds fetched data
//   retire_miss  : pulse, an issued slot retired without data
module fetch_slot_ring #(
   parameter int LATENCY     = 8,
   parameter int PIXEL_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   advance,
   input  logic                   alloc_issued,
   input  logic                   rsp_valid,
   input  logic [PIXEL_WIDTH-1:0] rsp_data,
   output logic [PIXEL_WIDTH-1:0] out_pixel,
   output logic                   out_valid,
   output logic                   retire_miss
);

   localparam int PW = $clog2(LATENCY);
   localparam int DW = $clog2(LATENCY + 1);

   typedef logic [PW-1:0] ptr_t;

   logic [LATENCY-1:0]     issued;
   logic [LATENCY-1:0]     filled;
   logic [PIXEL_WIDTH-1:0] data [LATENCY];
   ptr_t                   wr_ptr;
   ptr_t                   rd_ptr;
   ptr_t                   pend_ptr;
   logic                   pend_found;
   logic [DW-1:0]          discard_cnt;
   logic                   fill_hit;
   logic                   discard_dec;
   logic                   retire_fresh;

   function automatic ptr_t wrap_add(input ptr_t p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= LATENCY) s = s - LATENCY;
      return ptr_t'(s);
   endfunction

   // rd_ptr = wr_ptr - (LATENCY-1), which modulo LATENCY is wr_ptr + 1.
   assign rd_ptr = wrap_add(wr_ptr, 1);

   // Live slots are rd_ptr .. wr_ptr-1; the oldest one still waiting for
   // data is where the next in-order response belongs. A slot leaves this
   // window the edge it retires, which is how a missed slot gets skipped.
   always_comb begin
      pend_found = 1'b0;
      pend_ptr   = rd_ptr;
      for (int i = 0; i < LATENCY - 1; i++) begin
         if (!pend_found && issued[wrap_add(rd_ptr, i)] && !filled[wrap_add(rd_ptr, i)]) begin
            pend_found = 1'b1;
            pend_ptr   = wrap_add(rd_ptr, i);
         end
      end
   end

   // Responses owed to already-retired slots are swallowed first.
   assign fill_hit     = rsp_valid && (discard_cnt == '0) && pend_found;
   assign discard_dec  = rsp_valid && (discard_cnt != '0);
   assign retire_fresh = fill_hit && (pend_ptr == rd_ptr);
   assign retire_miss  = advance && issued[rd_ptr] && !filled[rd_ptr] && !retire_fresh;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issued      <= '0;
         filled      <= '0;
         for (int i = 0; i < LATENCY; i++) data[i] <= '0;
         wr_ptr      <= '0;
         discard_cnt <= '0;
         out_pixel   <= '0;
         out_valid   <= 1'b0;
      end else begin
         // Responses are taken even while the pipeline is stalled; the fill
         // target is never the slot at wr_ptr, so it cannot clash with alloc.
         if (fill_hit) begin
            filled[pend_ptr] <= 1'b1;
            data[pend_ptr]   <= rsp_data;
         end
         if (advance) begin
            issued[wr_ptr] <= alloc_issued;
            filled[wr_ptr] <= 1'b0;
            data[wr_ptr]   <= '0;
            wr_ptr         <= rd_ptr;
            if (retire_fresh) begin
               out_pixel <= rsp_data;
               out_valid <= 1'b1;
            end else if (filled[rd_ptr]) begin
               out_pixel <= data[rd_ptr];
               out_valid <= 1'b1;
            end else begin
               out_pixel <= '0;
               out_valid <= 1'b0;
            end
         end
         case ({retire_miss, discard_dec})
            2'b10: if (discard_cnt != DW'(LATENCY)) discard_cnt <= discard_cnt + 1'b1;
            2'b01: discard_cnt <= discard_cnt - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_foreground_fetch.sv
// Foreground fetch stage: turns a coordinate stream into frame-buffer reads
// and returns each pixel exactly LATENCY enabled cycles after its coordinate.
//   clk, rst_n        : pixel clock, synchronous active-low reset
//   output_enable     : pipeline advance for this cycle
//   fg_active         : coordinate valid
//   fg_pixel_x/_y     : signed coordinates, PRECISION+1 bits
//   mem               : frame-buffer read port (master side)
//   fg_pixel/fg_valid : aligned pixel, 0 and invalid when not fetched in time
//   underrun_count    : saturating count of refused requests and late data
module pipeline_foreground_fetch
   import pipeline_pkg::*;
#(
   parameter int RESOLUTION_X = DEF_RESOLUTION_X,
   parameter int RESOLUTION_Y = DEF_RESOLUTION_Y,
   parameter int PRECISION    = DEF_PRECISION,
   parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int LATENCY      = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   output_enable,
   input  logic                   fg_active,
   input  logic [PRECISION:0]     fg_pixel_x,
   input  logic [PRECISION:0]     fg_pixel_y,
   pipeline_foreground_fetch_if.master mem,
   output logic [PIXEL_WIDTH-1:0] fg_pixel,
   output logic                   fg_valid,
   output logic [15:0]            underrun_count
);

   logic [ADDR_WIDTH-1:0] addr_next;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic                  in_range;
   logic                  want_a;
   logic                  accept;
   logic                  refused;
   logic                  retire_miss;
   logic [1:0]            underrun_inc;
   logic [16:0]           underrun_sum;

   // Sign bit set means negative, so only the magnitude needs a bound check.
   assign in_range = !fg_pixel_x[PRECISION] && !fg_pixel_y[PRECISION]
                  && (int'(fg_pixel_x[PRECISION-1:0]) < RESOLUTION_X)
                  && (int'(fg_pixel_y[PRECISION-1:0]) < RESOLUTION_Y);

   generate
      if (RESOLUTION_X == DEF_RESOLUTION_X && ADDR_WIDTH == DEF_ADDR_WIDTH
          && PRECISION == DEF_PRECISION) begin : g_addr_shift
         assign addr_next = addr_of(fg_pixel_x[PRECISION-1:0], fg_pixel_y[PRECISION-1:0]);
      end else begin : g_addr_mul
         assign addr_next = ADDR_WIDTH'(int'(fg_pixel_y[PRECISION-1:0]) * RESOLUTION_X
                                      + int'(fg_pixel_x[PRECISION-1:0]));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_a <= '0;
         want_a <= 1'b0;
      end else if (output_enable) begin
         addr_a <= addr_next;
         want_a <= fg_active && in_range;
      end
   end

   assign mem.mem_req  = want_a && output_enable;
   assign mem.mem_addr = addr_a;
   assign accept       = mem.mem_req && mem.mem_ready;
   assign refused      = mem.mem_req && !mem.mem_ready;

   fetch_slot_ring #(
      .LATENCY     (LATENCY),
      .PIXEL_WIDTH (PIXEL_WIDTH)
   ) u_ring (
      .clk          (clk),
      .rst_n        (rst_n),
      .advance      (output_enable),
      .alloc_issued (accept),
      .rsp_valid    (mem.mem_rvalid),
      .rsp_data     (mem.mem_rdata),
      .out_pixel    (fg_pixel),
      .out_valid    (fg_valid),
      .retire_miss  (retire_miss)
   );

   // A refusal and a retire miss can land in the same cycle.
   assign underrun_inc = {1'b0, refused} + {1'b0, retire_miss};
   assign underrun_sum = {1'b0, underrun_count} + 17'(underrun_inc);

   always_ff @(posedge clk) begin
      if (!rst_n) underrun_count <= '0;
      else        underrun_count <= underrun_sum[16] ? 16'hFFFF : underrun_sum[15:0];
   end

endmodule

// File: tb/tb_pipeline_foreground_fetch.sv
module tb_pipeline_foreground_fetch;
   import pipeline_pkg::*;

   localparam int L  = 8;
   localparam int PW = 12;
   localparam int AW = 19;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          output_enable;
   logic          fg_active;
   logic [10:0]   fg_pixel_x;
   logic [10:0]   fg_pixel_y;
   logic [PW-1:0] fg_pixel;
   logic          fg_valid;
   logic [15:0]   underrun_count;

   pipeline_foreground_fetch_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) mem_if ();

   pipeline_foreground_fetch #(.LATENCY(L)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .output_enable  (output_enable),
      .fg_active      (fg_active),
      .fg_pixel_x     (fg_pixel_x),
      .fg_pixel_y     (fg_pixel_y),
      .mem            (mem_if),
      .fg_pixel       (fg_pixel),
      .fg_valid       (fg_valid),
      .underrun_count (underrun_count)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];        // per allocated slot: {issued, request id}
   int          mq_id[$];        // memory model: outstanding responses in order
   int          mq_due[$];
   int          last_due;
   pixel_t      rsp_data [2048];
   int          deliv_edge [2048];
   int          next_id;
   int          cyc;
   logic        sa_want;
   logic [AW-1:0] sa_addr;
   int          u_exp;
   logic        last_v;
   pixel_t      last_p;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < L - 1; i++) exp_q.push_back(16'h0);
      sa_want = 1'b0;
      sa_addr = '0;
      u_exp   = 0;
      last_v  = 1'b0;
      last_p  = '0;
   endtask

   // ---------------- driver: one clock cycle ----------------
   // rdy/lat apply to the request issued this cycle (the coordinate sampled
   // on the previous enabled edge).
   task automatic cycle(input logic rst_v, input logic en, input logic act,
                        input int x, input int y, input logic rdy, input int lat);
      logic        exp_req;
      logic        issued_now;
      logic        exp_v;
      pixel_t      exp_p;
      logic [15:0] ent;
      int          id;
      int          due;
      @(negedge clk);
      cyc++;
      rst_n         = rst_v;
      output_enable = en;
      fg_active     = act;
      fg_pixel_x    = 11'(x);
      fg_pixel_y    = 11'(y);
      #1;
      exp_req = rst_v && en && sa_want;
      check_eq("mem_req", 32'(mem_if.mem_req), 32'(exp_req));
      if (exp_req) check_eq("mem_addr", 32'(mem_if.mem_addr), 32'(sa_addr));
      mem_if.mem_ready = rdy;
      issued_now = 1'b0;
      id = 0;
      if (exp_req) begin
         if (rdy) begin
            id = next_id;
            next_id++;
            rsp_data[id]   = pixel_t'($urandom_range(0, 4095));
            deliv_edge[id] = -1;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_id.push_back(id);
            mq_due.push_back(due);
            issued_now = 1'b1;
         end else begin
            u_exp++;
         end
      end
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
         mem_if.mem_rvalid = 1'b1;
         mem_if.mem_rdata  = rsp_data[mq_id[0]];
         deliv_edge[mq_id[0]] = cyc;
         void'(mq_id.pop_front());
         void'(mq_due.pop_front());
      end else begin
         mem_if.mem_rvalid = 1'b0;
         mem_if.mem_rdata  = pixel_t'($urandom_range(0, 4095));
      end
      @(posedge clk);
      #1;
      if (!rst_v) begin
         model_reset();
         check_eq("rst_fg_valid", 32'(fg_valid), 32'(0));
         check_eq("rst_fg_pixel", 32'(fg_pixel), 32'(0));
         check_eq("rst_underrun", 32'(underrun_count), 32'(0));
      end else if (en) begin
         exp_q.push_back({issued_now, 15'(id)});
         ent   = exp_q.pop_front();
         exp_v = ent[15] && (deliv_edge[int'(ent[14:0])] != -1);
         if (ent[15] && !exp_v) u_exp++;
         exp_p = exp_v ? rsp_data[int'(ent[14:0])] : '0;
         check_eq("fg_valid", 32'(fg_valid), 32'(exp_v));
         check_eq("fg_pixel", 32'(fg_pixel), 32'(exp_p));
         check_eq("underrun_count", 32'(underrun_count), 32'(u_exp > 65535 ? 65535 : u_exp));
         last_v  = exp_v;
         last_p  = exp_p;
         sa_want = act && x >= 0 && x < 800 && y >= 0 && y < 600;
         sa_addr = AW'(y * 800 + x);
      end else begin
         check_eq("hold_fg_valid", 32'(fg_valid), 32'(last_v));
         check_eq("hold_fg_pixel", 32'(fg_pixel), 32'(last_p));
         check_eq("hold_underrun", 32'(underrun_count), 32'(u_exp));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n             = 1'b0;
      output_enable     = 1'b0;
      fg_active         = 1'b0;
      fg_pixel_x        = '0;
      fg_pixel_y        = '0;
      mem_if.mem_ready  = 1'b0;
      mem_if.mem_rvalid = 1'b0;
      mem_if.mem_rdata  = '0;
      last_due = 0;
      next_id  = 0;
      cyc      = 0;
      model_reset();

      cycle(0, 0, 0, 0, 0, 1, 3);
      cycle(0, 0, 0, 0, 0, 1, 3);

      // steady stream, ready, latency 3; first address is 2*800+5 = 1605
      cycle(1, 1, 1, 5, 2, 1, 3);
      for (int i = 0; i < 20; i++)
         cycle(1, 1, 1, $urandom_range(0, 799), $urandom_range(0, 599), 1, 3);

      // inactive and out-of-frame coordinates, plus frame corners
      cycle(1, 1, 0, 10, 10, 1, 3);
      cycle(1, 1, 1, -1, 3, 1, 3);
      cycle(1, 1, 1, 3, 600, 1, 3);
      cycle(1, 1, 1, 800, 0, 1, 3);
      cycle(1, 1, 1, 799, 599, 1, 3);
      cycle(1, 1, 1, 0, 0, 1, 3);
      cycle(1, 1, 1, -5, -5, 1, 3);

      // one refused request among good neighbours
      for (int i = 0; i < 5; i++)
         cycle(1, 1, 1, 7 * i, i, (i != 2), 3);

      // one response delayed 9 cycles, then a following request
      cycle(1, 1, 1, 100, 100, 1, 3);
      cycle(1, 1, 0, 0, 0, 1, 9);
      for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0, 1, 3);
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 200 + i, 50, 1, 3);

      // output_enable low for 4 cycles mid-stream
      for (int i = 0; i < 6; i++) cycle(1, 1, 1, 300 + i, 60, 1, 3);
      for (int i = 0; i < 4; i++) cycle(1, 0, 1, 700, 500, 1, 3);
      for (int i = 0; i < 10; i++) cycle(1, 1, 1, 400 + i, 70, 1, 3);
      for (int i = 0; i < L; i++) cycle(1, 1, 0, 0, 0, 1, 3);

      // reset with 3 requests outstanding; their late responses are stray
      cycle(1, 1, 1, 11, 11, 1, 6);
      cycle(1, 1, 1, 12, 11, 1, 6);
      cycle(1, 1, 1, 13, 11, 1, 6);
      cycle(1, 1, 0, 0, 0, 1, 6);
      cycle(0, 0, 0, 0, 0, 1, 3);
      for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0, 1, 3);
      for (int i = 0; i < 6; i++) cycle(1, 1, 1, 20 + i, 30, 1, 3);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         int rx;
         int ry;
         rx = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? -3 : 805) : int'($urandom_range(0, 799));
         ry = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? -2 : 600) : int'($urandom_range(0, 599));
         cycle(1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0), rx, ry,
               ($urandom_range(0, 19) != 0), $urandom_range(1, 8));
      end
      for (int i = 0; i < L + 4; i++) cycle(1, 1, 0, 0, 0, 1, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
